truth_table_sweeper: RTL
========================

// Module: truth_table_sweeper
// PURPOSE
//   Upstream stimulus/capture stage for a 3-input combinational logic-gate module.
//   Drives in1/in2/in3 through all 8 input combinations, waits a programmable settle time per vector,
//   then samples the gate output.
//   Produces the captured 8-bit truth table plus a pass/fail against an expected table.
//   Used for on-chip and bench verification of synthesized gate netlists.
// PARAMETERS
//   SETTLE_CYCLES  4      clocks each vector is held before sampling; legal range 2..255.
//   SYNC_STAGES    2      flops in the out_sample synchronizer; legal range 2..3.
//   EXPECTED       8'h22  golden table; bit i = expected out for {in1,in2,in3} == i.
// PORTS
//   clk            in   1  single clock; all state updates on rising edge.
//   rst            in   1  synchronous, active-high reset.
//   start          in   1  one-cycle request to begin a sweep.
//   out_sample     in   1  gate output under test; treated as asynchronous.
//   in1,in2,in3    out  1  stimulus to the gate; {in1,in2,in3} = current vector index.
//   busy           out  1  high while a sweep is in progress.
//   done           out  1  high from sweep completion until the next accepted start or rst.
//   table_out      out  8  captured truth table; bit i = sampled out for vector i.
//   match          out  1  (table_out == EXPECTED); valid only while done=1, else 0.
//   mismatch_mask  out  8  table_out ^ EXPECTED while done=1, else 0.
// BEHAVIOUR
//   Reset
//     - rst is sampled on clk; it wins over every other input.
//     - State=IDLE; in1..in3, busy, done, match = 0; table_out, mismatch_mask = 8'h00.
//     - Synchronizer flops and the settle counter are cleared.
//   FSM states: IDLE, SETTLE, SAMPLE, DONE.
//     - IDLE/DONE + start=1:
//         idx <= 0; cnt <= SETTLE_CYCLES-1; table_out <= 0; done <= 0; busy <= 1; state <= SETTLE.
//     - SETTLE:
//         cnt != 0 -> cnt <= cnt-1.
//         cnt == 0 -> state <= SAMPLE.
//     - SAMPLE:
//         table_out[idx] <= synchronized out_sample.
//         idx != 7 -> idx <= idx+1; cnt <= SETTLE_CYCLES-1; state <= SETTLE.
//         idx == 7 -> busy <= 0; done <= 1; state <= DONE.
//     - DONE: outputs held stable; start re-arms exactly as from IDLE.
//   Stimulus timing
//     - {in1,in2,in3} is registered from idx and changes on the same edge idx changes.
//     - Each vector is held SETTLE_CYCLES+1 clocks.
//     - Sample point sees out_sample as it was SYNC_STAGES clocks earlier;
//       SETTLE_CYCLES must be >= SYNC_STAGES.
//   Latency
//     - done rises 8*(SETTLE_CYCLES+1) clocks after the edge that accepts start.
//     - SETTLE_CYCLES=4 gives 40 clocks.
//   Boundary conditions
//     - start while busy: ignored; no restart and no state change.
//     - start and rst in the same cycle: reset wins.
//     - rst mid-sweep: abort to IDLE with reset values; partial table discarded.
//     - idx wraps only via the restart path, never 7->0 inside a sweep.
//     - Inputs stay at the last vector (3'b111) while in DONE.
//     - match and mismatch_mask are combinational from table_out and done; no extra latency.
// STRUCTURE
//   Package cello_sweep_pkg:
//     - sweep_state_t enum {IDLE, SETTLE, SAMPLE, DONE}.
//     - localparam N_VECTORS = 8; localparam IDX_W = 3.
//   Sub-module input_synchronizer (param STAGES): synchronous-reset flop chain for out_sample.
//   Top level contains the FSM, settle counter, idx register and table register.
// TESTING
//   1. Model gate (out=1 for idx 1,5), SETTLE=4, pulse start
//        -> done at +40 clocks, table_out=8'h22, match=1, mismatch_mask=8'h00.
//   2. out_sample stuck 0 -> table_out=8'h00, match=0, mismatch_mask=8'h22.
//      out_sample stuck 1 -> table_out=8'hFF, match=0, mismatch_mask=8'hDD.
//   3. Pulse start again at cycle 10 of a sweep -> ignored; done still at +40; table_out=8'h22.
//   4. Assert rst while idx=3
//        -> next cycle: IDLE, busy=0, done=0, inputs 000, table_out=8'h00.
//   5. From DONE, pulse start
//        -> done drops the next cycle, table_out clears, new sweep completes +40 clocks later.
//   6. Model gate with a 3-clock output delay and SETTLE=2 (too short)
//        -> mismatch reported; rerun with SETTLE=6 -> match=1.

Source files
------------

// File: rtl/cello_sweep_pkg.sv
// Shared types and sizing for the truth-table sweeper: FSM state encoding
// and the vector-space dimensions of a 3-input gate.
package cello_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } sweep_state_t;

  localparam int N_VECTORS = 8;
  localparam int IDX_W     = 3;

endpackage

// File: rtl/truth_table_sweeper_input_synchronizer.sv
// Flop chain that brings the asynchronous gate output into the clk domain.
// Clearing on rst keeps a stale level from leaking into the next sweep.
module input_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input gate through all 8 vectors, holds each SETTLE_CYCLES+1 clocks,
// captures the synchronized output per vector and compares against EXPECTED.
module truth_table_sweeper
  import cello_sweep_pkg::*;
#(
  parameter int           SETTLE_CYCLES = 4,
  parameter int           SYNC_STAGES   = 2,
  parameter logic [7:0]   EXPECTED      = 8'h22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       out_sample,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       match,
  output logic [7:0] mismatch_mask
);

  localparam logic [7:0]       CNT_RELOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_VECTORS - 1);

  sweep_state_t     state_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       cnt_q;
  logic [7:0]       table_q;
  logic             busy_q;
  logic             done_q;
  logic             sample_sync;

  input_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (out_sample),
    .sync_o  (sample_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            idx_q   <= '0;
            cnt_q   <= CNT_RELOAD;
            table_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          table_q[idx_q] <= sample_sync;
          // idx stays on the last vector after the sweep; only a restart clears it.
          if (idx_q != LAST_IDX) begin
            idx_q   <= idx_q + 1'b1;
            cnt_q   <= CNT_RELOAD;
            state_q <= SETTLE;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {in1, in2, in3} = idx_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign table_out       = table_q;
  assign match           = done_q && (table_q == EXPECTED);
  assign mismatch_mask   = done_q ? (table_q ^ EXPECTED) : 8'h00;

endmodule
